// File: rtl/prf_cbd_buffer_pkg.sv
// prf_cbd_buffer_pkg: shared constants, FSM state type and slot helper for
// the PRF-to-CBD byte buffer.
//   BUF_BITS/BUF_BYTES : assembled buffer size (1536 bits / 192 slots)
//   ETA2_BYTES/ETA3_BYTES : stream bytes consumed per fill for each eta
//   ETA2_SLOT_OFS      : first slot written when eta=2
//   ETA_2/ETA_3        : eta codes presented to the cbd block
package prf_cbd_buffer_pkg;

  localparam int unsigned BUF_BITS      = 1536;
  localparam int unsigned BUF_BYTES     = 192;
  localparam int unsigned ETA2_BYTES    = 128;
  localparam int unsigned ETA3_BYTES    = 192;
  localparam int unsigned ETA2_SLOT_OFS = 64;
  localparam int unsigned CNT_W         = 6;   // covers 48 words at DW=32
  localparam int unsigned SLOT_W        = 8;   // covers slot 0..191

  localparam logic [1:0] ETA_2 = 2'd2;
  localparam logic [1:0] ETA_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // MSB bit index of a slot; slot 0 sits at the top of the buffer
  function automatic logic [10:0] slot_msb(input logic [SLOT_W-1:0] slot);
    return 11'(BUF_BITS - 1) - {slot, 3'b000};
  endfunction

endpackage

// File: rtl/prf_cbd_buffer_if.sv
// prf_cbd_buffer_if: handshake/bus bundle between the PRF word source, the
// byte buffer and the cbd consumer.
//   i_start/i_eta            : fill request and eta select
//   i_wdata/i_wvalid/o_wready: PRF word stream (byte 0 in the top byte)
//   o_ibytes/o_eta/o_valid/i_ready : assembled buffer to cbd
//   o_busy                   : fill or hold in progress
//   o_err                    : sticky protocol error (only with PRF_BUF_ERR_EN)
// Modports: slave = buffer block, master = surrounding logic.
interface prf_cbd_buffer_if #(
  parameter int unsigned DW = 64
);
  import prf_cbd_buffer_pkg::*;

  logic                i_start;
  logic [1:0]          i_eta;
  logic [DW-1:0]       i_wdata;
  logic                i_wvalid;
  logic                o_wready;
  logic [BUF_BITS-1:0] o_ibytes;
  logic [1:0]          o_eta;
  logic                o_valid;
  logic                i_ready;
  logic                o_busy;
`ifdef PRF_BUF_ERR_EN
  logic                o_err;
`endif

  modport slave (
    input  i_start, i_eta, i_wdata, i_wvalid, i_ready,
    output o_wready, o_ibytes, o_eta, o_valid, o_busy
`ifdef PRF_BUF_ERR_EN
    , output o_err
`endif
  );

  modport master (
    output i_start, i_eta, i_wdata, i_wvalid, i_ready,
    input  o_wready, o_ibytes, o_eta, o_valid, o_busy
`ifdef PRF_BUF_ERR_EN
    , input o_err
`endif
  );

endinterface

// File: rtl/prf_word_sel.sv
// prf_word_sel: combinational decoder from (word counter, latched eta) to the
// first buffer slot written by the current word and a last-word flag.
//   cnt    : word counter
//   eta    : latched eta code (2 or 3)
//   base_c : slot receiving stream byte 0 of this word
//   last_c : this word completes the fill
module prf_word_sel
  import prf_cbd_buffer_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic [1:0]        eta,
  output logic [SLOT_W-1:0] base_c,
  output logic              last_c
);

  localparam int unsigned BPW = DW / 8;
  localparam int unsigned N2  = ETA2_BYTES * 8 / DW;
  localparam int unsigned N3  = ETA3_BYTES * 8 / DW;

  logic              eta2;
  logic [SLOT_W-1:0] ofs;

  // eta=2 streams fill the upper 128 slots, leaving slots 0..63 zero
  always_comb begin
    eta2   = (eta == ETA_2);
    ofs    = eta2 ? SLOT_W'(ETA2_SLOT_OFS) : '0;
    base_c = SLOT_W'(cnt) * SLOT_W'(BPW) + ofs;
    last_c = eta2 ? (cnt == CNT_W'(N2 - 1)) : (cnt == CNT_W'(N3 - 1));
  end

endmodule

// File: rtl/prf_cbd_buffer.sv
// prf_cbd_buffer: collects PRF words into the 1536-bit byte buffer consumed
// by the cbd sampler. IDLE -> FILL on i_start (buffer zeroed, eta latched),
// FILL -> HOLD on the last word, HOLD -> IDLE when the buffer is taken.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : prf_cbd_buffer_if.slave (word stream in, buffer out)
// Optional macro PRF_BUF_ERR_EN adds the sticky bus.o_err protocol flag.
module prf_cbd_buffer
  import prf_cbd_buffer_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  prf_cbd_buffer_if.slave bus
);

  localparam int unsigned BPW = DW / 8;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [BUF_BITS-1:0] buf_q;
  logic [1:0]          eta_q;
  logic                valid_q, wready_q, busy_q;
  logic                start_acc_c, wr_c, last_c;
  logic [SLOT_W-1:0]   base_c;

  prf_word_sel #(.DW(DW)) u_word_sel (
    .cnt    (cnt_q),
    .eta    (eta_q),
    .base_c (base_c),
    .last_c (last_c)
  );

  // next state and transfer strobes
  always_comb begin
    state_d     = state_q;
    start_acc_c = 1'b0;
    wr_c        = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.i_start) begin
        start_acc_c = 1'b1;
        state_d     = ST_FILL;
      end
      ST_FILL: if (bus.i_wvalid) begin
        wr_c = 1'b1;
        if (last_c) state_d = ST_HOLD;
      end
      ST_HOLD: if (bus.i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // buffer, counter, latched eta and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      buf_q    <= '0;
      eta_q    <= ETA_3;
      valid_q  <= 1'b0;
      wready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // flags follow the next state so they line up with it
      valid_q  <= (state_d == ST_HOLD);
      wready_q <= (state_d == ST_FILL);
      busy_q   <= (state_d != ST_IDLE);
      if (start_acc_c) begin
        cnt_q <= '0;
        eta_q <= (bus.i_eta == ETA_2) ? ETA_2 : ETA_3;
        buf_q <= '0;
      end else if (wr_c) begin
        for (int j = 0; j < int'(BPW); j++) begin
          buf_q[slot_msb(base_c + SLOT_W'(j)) -: 8] <= bus.i_wdata[DW-1-8*j -: 8];
        end
        // counter parks on the last word until the next start
        if (!last_c) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.o_ibytes = buf_q;
  assign bus.o_eta    = eta_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_wready = wready_q;
  assign bus.o_busy   = busy_q;

`ifdef PRF_BUF_ERR_EN
  logic err_q;

  // sticky: data offered outside FILL or consume requested outside HOLD
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            err_q <= 1'b0;
    else if (start_acc_c) err_q <= 1'b0;
    else if ((bus.i_wvalid && state_q != ST_FILL) ||
             (bus.i_ready  && state_q != ST_HOLD))
      err_q <= 1'b1;
  end

  assign bus.o_err = err_q;
`endif

endmodule
